bram_rd_sched: RTL and testbench
================================

Name: bram_rd_sched

Overview:
- Drains the ping-pong capture BRAMs (bank A, bank B) after the capture controller flags a finished acquisition.
- Streams the captured samples, in order, on an AXI-Stream master toward the DMA.
- Generates BRAM port-B read addresses and enables, and absorbs backpressure with a 2-entry skid buffer.
- Drives per-bank busy flags back to the capture controller's rdy_w input, so a bank is never overwritten while it is being read.

Parameters:
- DATA_W, 32, sample/word width.
- BANK_DEPTH, 2048, words per bank; total capacity 2*BANK_DEPTH.
- ADDR_STEP, 4, byte-address increment per word.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  3  capture status: bit0 bank A full, bit1 bank B full, bit2 early stop (partial frame).
- size_data  in  32  total valid words in the frame, range 1..2*BANK_DEPTH.
- bram_addr  out  32  byte read address, shared by both banks.
- en_rd_a  out  1  bank A read enable.
- en_rd_b  out  1  bank B read enable.
- dout_a  in  DATA_W  bank A read data; 1-cycle latency after enable.
- dout_b  in  DATA_W  bank B read data; 1-cycle latency after enable.
- m_tdata  out  DATA_W  stream data.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  asserted on the final word of the frame.
- rdy_w  out  2  busy flag per bank: bit0 A, bit1 B.
- done  out  1  one-cycle pulse when a frame has been fully sent.
- ovf_cnt  out  16  number of frames dropped because they arrived while busy; saturating.

Behaviour:
- Reset: all outputs 0. State IDLE, skid buffer empty, counters cleared.
- Start event: rdy goes from 0 to nonzero (registered edge detect).
  - In IDLE: latch size_data. If it exceeds 2*BANK_DEPTH, clamp it to 2*BANK_DEPTH. If it is 0, jump straight to DONE with no beats.
  - Word split: words_a = min(size, BANK_DEPTH); words_b = size - words_a.
  - rdy_w: bit0 is set on the start event; bit1 is set on the start event only if words_b > 0.
- States:
  - IDLE to RD_A on a start event.
  - RD_A: issue reads at bram_addr = 0, 4, 8, … When words_a reads have been issued, go to RD_B if words_b > 0, otherwise to FLUSH.
  - RD_B: bram_addr restarts at 0. When words_b reads have been issued, go to FLUSH.
  - FLUSH: wait for the skid buffer to empty and the last beat to be accepted (tvalid & tready & tlast), then go to DONE.
  - DONE: one cycle. Pulse done, clear rdy_w, return to IDLE.
- Issue rule: a read is issued (en_rd_x = 1 for one cycle) only when fifo_count + inflight < 2. At most one read is in flight, so no data is lost under any m_tready pattern.
- Data capture: the word returns the cycle after issue, selected from dout_a or dout_b according to the bank that was issued. It is pushed into the skid buffer and carries a last tag if it is word number size-1.
- Output:
  - m_tvalid = (buffer not empty); m_tdata and m_tlast come from the head entry.
  - Pop on tvalid & tready.
  - The buffer may push and pop in the same cycle.
  - m_tdata and m_tlast stay stable while tvalid & !tready.
- Early release: rdy_w[0] clears the cycle after the last bank-A word is popped, when words_b > 0. This lets the capture side reuse bank A early.
- Overflow: a start event outside IDLE is ignored. ovf_cnt increments by 1 and saturates at 0xFFFF.
- Throughput: one word every 2 cycles sustained with m_tready = 1. The first tvalid appears 2 cycles after the start event.
- rst asserted mid-frame: everything aborts, outputs go to 0, and no done pulse is produced.

Decomposition:
- Shared package: state encoding (IDLE, RD_A, RD_B, FLUSH, DONE), the rdy bit-index constants, and BANK_DEPTH.
- Sub-module: skid_fifo2, a generic 2-entry FIFO with DATA_W+1 bits per entry, count output, and simultaneous push/pop.

Test Plan:
- size_data = 100, rdy 000→001, m_tready = 1 → exactly 100 beats with data = bank A words 0..99; tlast only on beat 100; rdy_w = 01 throughout; done pulses once.
- size_data = 3000, rdy → 011 → 2048 beats from A, then 952 from B; bram_addr wraps to 0 at the bank switch; rdy_w goes 11 → 10 after the last A pop → 00 at done.
- size_data = 4096 with m_tready toggling in a random 30% pattern → 4096 beats, no loss or duplication; tdata is held during stalls.
- size_data = 5000 → clamped: 4096 beats, tlast on beat 4096.
- Second rdy edge during RD_A → ignored; ovf_cnt = 1; the current frame completes unaffected.
- rst pulsed at beat 500 of a 1000-word frame → all outputs 0 the next cycle; no done pulse; a fresh frame afterwards streams correctly.

Source files
------------

// File: rtl/bram_rd_sched_pkg.sv
// ---------------------------------------------------------------------------
// bram_rd_sched_pkg
// Shared definitions for the ping-pong BRAM read scheduler: the scheduler
// state encoding, the bit positions inside the capture status word 'rdy'
// and the per-bank depth in words.
// ---------------------------------------------------------------------------
package bram_rd_sched_pkg;

   // Words held by one capture bank; a frame spans at most two banks.
   localparam int BANK_DEPTH = 2048;

   // Bit positions in the capture status word (and in the busy flags).
   localparam int RDY_A_BIT    = 0;
   localparam int RDY_B_BIT    = 1;
   localparam int RDY_STOP_BIT = 2;

   // Read scheduler states.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_A,
      ST_RD_B,
      ST_FLUSH,
      ST_DONE
   } state_t;

endpackage

// File: rtl/skid_fifo2.sv
// ---------------------------------------------------------------------------
// skid_fifo2
// Two-entry FIFO used as the output skid buffer. Each entry carries a data
// word plus one tag bit (DATA_W+1 bits total). Push and pop may happen in
// the same cycle. The head entry (dout) only changes on a pop, so it stays
// stable while the consumer stalls.
//
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   push, din write request and entry to store
//   pop       read request (head is removed at the clock edge)
//   dout      head entry
//   count     number of valid entries (0..2)
// ---------------------------------------------------------------------------
module skid_fifo2 #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W:0]   din,
   input  logic              pop,
   output logic [DATA_W:0]   dout,
   output logic [1:0]        count
);

   logic [DATA_W:0] mem0;
   logic [DATA_W:0] mem1;
   logic            pop_ok;
   logic            push_ok;

   // A pop is only honoured when something is stored; a push into a full
   // buffer is only honoured when the head leaves in the same cycle.
   assign pop_ok  = pop && (count != 2'd0);
   assign push_ok = push && ((count != 2'd2) || pop_ok);
   assign dout    = mem0;

   // Shift-register storage: mem0 is always the head, mem1 the second entry.
   // On a pop the second entry moves forward; a concurrent push lands in
   // whichever slot is free after that move.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem0  <= '0;
         mem1  <= '0;
         count <= 2'd0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10: begin
               if (count == 2'd0) begin
                  mem0 <= din;
               end else begin
                  mem1 <= din;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               mem0  <= mem1;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  mem0 <= din;
               end else begin
                  mem0 <= mem1;
                  mem1 <= din;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: rtl/bram_rd_sched.sv
// ---------------------------------------------------------------------------
// bram_rd_sched
// Drains the ping-pong capture BRAMs (bank A then bank B) after the capture
// controller reports a finished acquisition, and streams the samples in
// order on an AXI-Stream master. Reads are paced so that at most one read
// is in flight and the 2-entry skid buffer can never overflow, whatever the
// m_tready pattern. Per-bank busy flags tell the capture side when a bank
// may be overwritten again.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy[2:0]            capture status (A full, B full, early stop)
//   size_data[31:0]     words in the frame (clamped to 2*BANK_DEPTH)
//   bram_addr[31:0]     byte read address shared by both banks
//   en_rd_a, en_rd_b    per-bank read enables
//   dout_a, dout_b      per-bank read data, one cycle after enable
//   m_tdata/m_tvalid/m_tready/m_tlast   AXI-Stream master
//   rdy_w[1:0]          per-bank busy flags back to the capture side
//   done                one-cycle pulse after the last beat is accepted
//   ovf_cnt[15:0]       saturating count of ignored (dropped) frames
// ---------------------------------------------------------------------------
module bram_rd_sched
   import bram_rd_sched_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_STEP = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        rdy,
   input  logic [31:0]       size_data,
   output logic [31:0]       bram_addr,
   output logic              en_rd_a,
   output logic              en_rd_b,
   input  logic [DATA_W-1:0] dout_a,
   input  logic [DATA_W-1:0] dout_b,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tlast,
   output logic [1:0]        rdy_w,
   output logic              done,
   output logic [15:0]       ovf_cnt
);

   localparam int              CNT_W      = $clog2(2*BANK_DEPTH + 1);
   localparam logic [CNT_W-1:0] FRAME_MAX  = CNT_W'(2*BANK_DEPTH);
   localparam logic [CNT_W-1:0] BANK_WORDS = CNT_W'(BANK_DEPTH);
   localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

   state_t            state;
   state_t            state_nxt;

   logic [2:0]        rdy_q;
   logic              start;

   logic [CNT_W-1:0]  size_clamped;
   logic [CNT_W-1:0]  words_a_nxt;
   logic [CNT_W-1:0]  words_b_nxt;
   logic [CNT_W-1:0]  size_r;
   logic [CNT_W-1:0]  words_a_r;
   logic [CNT_W-1:0]  words_b_r;

   logic [CNT_W-1:0]  rd_cnt;
   logic [CNT_W-1:0]  push_idx;
   logic [CNT_W-1:0]  pop_idx;
   logic              infl_valid;
   logic              infl_bank;
   logic              can_issue;
   logic              issue;
   logic              rd_last;

   logic              push;
   logic              push_last;
   logic              pop;
   logic [DATA_W:0]   fifo_din;
   logic [DATA_W:0]   fifo_dout;
   logic [1:0]        fifo_count;

   // A new acquisition is the status word leaving all-zero.
   assign start = (rdy[RDY_STOP_BIT:RDY_A_BIT] != 3'b000) && (rdy_q == 3'b000);

   // Clamp the requested frame length and split it over the two banks:
   // bank A is filled first, bank B holds whatever does not fit in A.
   always_comb begin
      size_clamped = FRAME_MAX;
      if (size_data <= 32'(2*BANK_DEPTH)) begin
         size_clamped = size_data[CNT_W-1:0];
      end
      words_a_nxt = (size_clamped > BANK_WORDS) ? BANK_WORDS : size_clamped;
      words_b_nxt = size_clamped - words_a_nxt;
   end

   // Read pacing: the buffer slots already taken plus the read still in
   // flight must leave room for one more word, and only one read may be in
   // flight at a time. This caps the rate at one word per two cycles but
   // guarantees the skid buffer never has to drop a returning word.
   assign can_issue = ((fifo_count + {1'b0, infl_valid}) < 2'd2) && !infl_valid;

   // State register of the scheduler FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and read-enable decode. A zero-length frame skips the read
   // states entirely and only produces the done pulse. FLUSH waits for the
   // tagged final beat to be accepted before completing the frame.
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      rd_last   = 1'b0;
      en_rd_a   = 1'b0;
      en_rd_b   = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = (size_clamped == '0) ? ST_DONE : ST_RD_A;
            end
         end
         ST_RD_A: begin
            issue   = can_issue;
            en_rd_a = can_issue;
            rd_last = can_issue && (rd_cnt == words_a_r - ONE);
            if (rd_last) begin
               state_nxt = (words_b_r != '0) ? ST_RD_B : ST_FLUSH;
            end
         end
         ST_RD_B: begin
            issue   = can_issue;
            en_rd_b = can_issue;
            rd_last = can_issue && (rd_cnt == words_b_r - ONE);
            if (rd_last) begin
               state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (pop && m_tlast) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // The word address restarts at zero in each bank.
   assign bram_addr = 32'(rd_cnt) * 32'(ADDR_STEP);

   // Returning read data is pushed unconditionally the cycle after issue;
   // the pacing rule above guarantees there is room for it. The final word
   // of the frame carries the last tag into the buffer.
   assign push      = infl_valid;
   assign push_last = (push_idx == size_r - ONE);
   assign fifo_din  = {push_last, (infl_bank ? dout_b : dout_a)};

   skid_fifo2 #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (fifo_din),
      .pop   (pop),
      .dout  (fifo_dout),
      .count (fifo_count)
   );

   assign m_tvalid = (fifo_count != 2'd0);
   assign m_tdata  = fifo_dout[DATA_W-1:0];
   assign m_tlast  = fifo_dout[DATA_W];
   assign pop      = m_tvalid && m_tready;

   // Frame bookkeeping: edge-detect history, latched frame geometry, read
   // and word counters, in-flight tracking, busy flags and overflow count.
   // Bank A's busy flag drops right after its last word leaves the buffer
   // when the frame continues into bank B, so capture can refill A early.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdy_q      <= 3'b000;
         size_r     <= '0;
         words_a_r  <= '0;
         words_b_r  <= '0;
         rd_cnt     <= '0;
         push_idx   <= '0;
         pop_idx    <= '0;
         infl_valid <= 1'b0;
         infl_bank  <= 1'b0;
         rdy_w      <= 2'b00;
         ovf_cnt    <= 16'd0;
      end else begin
         rdy_q      <= rdy;
         infl_valid <= issue;

         if (issue) begin
            infl_bank <= (state == ST_RD_B);
            rd_cnt    <= rd_last ? '0 : rd_cnt + ONE;
         end

         if (state == ST_IDLE && start) begin
            size_r    <= size_clamped;
            words_a_r <= words_a_nxt;
            words_b_r <= words_b_nxt;
            push_idx  <= '0;
            pop_idx   <= '0;
         end else begin
            if (push) begin
               push_idx <= push_idx + ONE;
            end
            if (pop) begin
               pop_idx <= pop_idx + ONE;
            end
         end

         if (state == ST_IDLE && start) begin
            rdy_w[RDY_A_BIT] <= 1'b1;
            rdy_w[RDY_B_BIT] <= (words_b_nxt != '0);
         end else if (state == ST_DONE) begin
            rdy_w <= 2'b00;
         end else if (pop && (pop_idx == words_a_r - ONE) && (words_b_r != '0)) begin
            rdy_w[RDY_A_BIT] <= 1'b0;
         end

         if (start && (state != ST_IDLE) && (ovf_cnt != 16'hFFFF)) begin
            ovf_cnt <= ovf_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_bram_rd_sched.sv
// ---------------------------------------------------------------------------
// tb_bram_rd_sched
// Scoreboard bench for bram_rd_sched. Bank contents are random; each frame
// the expected beat sequence is computed from the frame length alone and
// queued, and an independent monitor checks every accepted beat, stall
// hold, read address order and busy-flag state against it.
// ---------------------------------------------------------------------------
module tb_bram_rd_sched;

   localparam int DEPTH = 2048;

   logic        clk;
   logic        rst;
   logic [2:0]  rdy;
   logic [31:0] size_data;
   logic [31:0] bram_addr;
   logic        en_rd_a;
   logic        en_rd_b;
   logic [31:0] dout_a;
   logic [31:0] dout_b;
   logic [31:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready;
   logic        m_tlast;
   logic [1:0]  rdy_w;
   logic        done;
   logic [15:0] ovf_cnt;

   logic [31:0] mem_a [DEPTH];
   logic [31:0] mem_b [DEPTH];
   logic [32:0] exp_q [$];
   logic [32:0] mon_word;
   logic [1:0]  mon_rdy_w;

   int n_cmp = 0;
   int n_err = 0;
   int beat_cnt = 0;
   int done_cnt = 0;
   int exp_beats = 0;
   int a_iss = 0;
   int b_iss = 0;
   int wa = 0;
   int wb = 0;
   int exp_ovf = 0;
   int ready_pct = 100;

   bram_rd_sched #(
      .DATA_W    (32),
      .ADDR_STEP (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rdy       (rdy),
      .size_data (size_data),
      .bram_addr (bram_addr),
      .en_rd_a   (en_rd_a),
      .en_rd_b   (en_rd_b),
      .dout_a    (dout_a),
      .dout_b    (dout_b),
      .m_tdata   (m_tdata),
      .m_tvalid  (m_tvalid),
      .m_tready  (m_tready),
      .m_tlast   (m_tlast),
      .rdy_w     (rdy_w),
      .done      (done),
      .ovf_cnt   (ovf_cnt)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global watchdog so the run always ends.
   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Two synchronous-read BRAM banks with one cycle of read latency.
   always @(posedge clk) begin
      if (en_rd_a) dout_a <= mem_a[bram_addr[12:2]];
      if (en_rd_b) dout_b <= mem_b[bram_addr[12:2]];
   end

   // Downstream consumer: ready is high with probability ready_pct percent.
   initial begin
      m_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         m_tready = ($urandom_range(99) < ready_pct);
      end
   end

   task automatic checkOutput(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: checks read issue order/address, every stalled and accepted
   // beat against the scoreboard head, and the busy flags at each beat.
   always @(negedge clk) begin
      if (!rst) begin
         if (en_rd_a) begin
            checkOutput("rd_a_addr", bram_addr, 4*a_iss);
            checkOutput("rd_a_in_range", (a_iss < wa) ? 1 : 0, 1);
            a_iss++;
         end
         if (en_rd_b) begin
            checkOutput("rd_b_addr", bram_addr, 4*b_iss);
            checkOutput("rd_b_order", ((a_iss == wa) && (b_iss < wb)) ? 1 : 0, 1);
            b_iss++;
         end
         if (m_tvalid) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("[TB] FAIL extra_beat: got data %0h with nothing expected", m_tdata);
            end else begin
               mon_word = exp_q[0];
               if (m_tready) begin
                  mon_rdy_w[1] = (wb > 0);
                  mon_rdy_w[0] = !((wb > 0) && (beat_cnt >= wa));
                  checkOutput("tdata", m_tdata, mon_word[31:0]);
                  checkOutput("tlast", m_tlast, mon_word[32]);
                  checkOutput("rdy_w_beat", rdy_w, mon_rdy_w);
                  void'(exp_q.pop_front());
                  beat_cnt++;
               end else begin
                  checkOutput("tdata_hold", m_tdata, mon_word[31:0]);
               end
            end
         end
         if (done) done_cnt++;
      end
   end

   // Queue the expected frame and raise the capture status word.
   task automatic applyStimulus(input int size, input logic [2:0] rv, input int pct);
      int n;
      logic [32:0] entry;
      n = (size > 2*DEPTH) ? 2*DEPTH : size;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         entry = {(i == n-1), ((i < DEPTH) ? mem_a[i] : mem_b[i-DEPTH])};
         exp_q.push_back(entry);
      end
      exp_beats = n;
      wa        = (n > DEPTH) ? DEPTH : n;
      wb        = n - wa;
      a_iss     = 0;
      b_iss     = 0;
      beat_cnt  = 0;
      done_cnt  = 0;
      ready_pct = pct;
      size_data = size;
      @(posedge clk);
      #1;
      rdy = rv;
   endtask

   // Wait for the frame to finish and check the end-of-frame state.
   task automatic waitFrame(input int budget);
      int cyc;
      cyc = 0;
      while (done_cnt == 0 && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      if (done_cnt == 0) begin
         n_cmp++;
         n_err++;
         $display("[TB] FAIL done_timeout: no done after %0d cycles, %0d of %0d beats", cyc, beat_cnt, exp_beats);
      end
      checkOutput("beat_count", beat_cnt, exp_beats);
      checkOutput("beats_left", exp_q.size(), 0);
      repeat (3) @(negedge clk);
      checkOutput("done_pulses", done_cnt, 1);
      checkOutput("rdy_w_idle", rdy_w, 0);
      checkOutput("ovf_cnt", ovf_cnt, exp_ovf);
      @(posedge clk);
      #1;
      rdy = 3'b000;
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Outputs expected to be zero after a reset.
   task automatic checkZero(input string tag);
      checkOutput({tag, "_tvalid"}, m_tvalid, 0);
      checkOutput({tag, "_tdata"}, m_tdata, 0);
      checkOutput({tag, "_tlast"}, m_tlast, 0);
      checkOutput({tag, "_en_rd_a"}, en_rd_a, 0);
      checkOutput({tag, "_en_rd_b"}, en_rd_b, 0);
      checkOutput({tag, "_addr"}, bram_addr, 0);
      checkOutput({tag, "_rdy_w"}, rdy_w, 0);
      checkOutput({tag, "_done"}, done, 0);
      checkOutput({tag, "_ovf"}, ovf_cnt, 0);
   endtask

   // Main sequence: reset, then the directed and random frames.
   initial begin
      int sz;
      int cyc;
      for (int i = 0; i < DEPTH; i++) begin
         mem_a[i] = $urandom;
         mem_b[i] = $urandom;
      end
      dout_a    = '0;
      dout_b    = '0;
      rst       = 1'b1;
      rdy       = 3'b000;
      size_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkZero("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] frame of 100 words from bank A, first-beat latency");
      applyStimulus(100, 3'b001, 100);
      @(posedge clk);
      @(negedge clk);
      checkOutput("latency_c1", m_tvalid, 0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("latency_c2", m_tvalid, 0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("latency_c3", m_tvalid, 1);
      waitFrame(1000);

      $display("[TB] frame of 3000 words across both banks");
      applyStimulus(3000, 3'b011, 100);
      waitFrame(8000);

      $display("[TB] full frame of 4096 words with random backpressure");
      applyStimulus(4096, 3'b011, 70);
      waitFrame(20000);

      $display("[TB] oversize frame of 5000 words");
      applyStimulus(5000, 3'b011, 100);
      waitFrame(10000);

      $display("[TB] zero-length frame");
      applyStimulus(0, 3'b001, 100);
      waitFrame(50);

      $display("[TB] second start during a frame");
      applyStimulus(1000, 3'b001, 100);
      repeat (10) @(posedge clk);
      #1;
      rdy = 3'b000;
      @(posedge clk);
      #1;
      rdy = 3'b100;
      exp_ovf = 1;
      waitFrame(4000);

      $display("[TB] random frames");
      for (int k = 0; k < 3; k++) begin
         sz = $urandom_range(1, 1500);
         applyStimulus(sz, 3'($urandom_range(1, 7)), $urandom_range(50, 100));
         waitFrame(sz*6 + 200);
      end

      $display("[TB] reset in the middle of a 1000-word frame");
      applyStimulus(1000, 3'b001, 100);
      cyc = 0;
      while (beat_cnt < 500 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("reach_beat_500", (beat_cnt >= 500) ? 1 : 0, 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      rdy = 3'b000;
      @(posedge clk);
      @(negedge clk);
      checkZero("midrst");
      exp_ovf = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      repeat (6) @(negedge clk);
      checkOutput("no_done_after_rst", done_cnt, 0);
      checkOutput("idle_after_rst", m_tvalid, 0);
      @(posedge clk);
      #1;

      $display("[TB] fresh frame after reset");
      applyStimulus(200, 3'b010, 80);
      waitFrame(2000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
